// File: rtl/tst_mode_pkg.sv
// Shared constants and FSM state type for the tester-interface mode decoder.
package tst_mode_pkg;

   localparam int          KEY_W_DEF    = 16;
   localparam logic [15:0] KEY_SCAN_DEF = 16'hA5C3;
   localparam logic [15:0] KEY_IDDQ_DEF = 16'h5A3C;
   localparam int          TMO_W_DEF    = 12;

   // Consecutive high tst samples required before a key attempt may start
   // when the TST deglitch filter is built in.
   localparam int          DEGLITCH_LEN = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_CHECK = 3'd2,
      ST_SCAN  = 3'd3,
      ST_IDDQ  = 3'd4,
      ST_LOCK  = 3'd5
   } state_t;

endpackage

// File: rtl/tst_sync_edge.sv
// Two-flop synchronizer for one asynchronous pad, plus a third flop that
// lets the caller see a single-cycle rising edge of the synchronized level.
module tst_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic sync,
   output logic rise
);

   logic meta;
   logic sync_q;
   logic prev;

   // Shift the pad through the metastability flop, the synced flop and the
   // edge-reference flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         prev   <= 1'b0;
      end else begin
         meta   <= pad;
         sync_q <= meta;
         prev   <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev;

endmodule

// File: rtl/tst_mode_dec.sv
// Test-mode entry decoder: captures a serial key strobed on SCL/SDA while
// TST is high and grants scan or IDDQ mode until TST is released.
// Optional build macro TST_DEGLITCH_EN requires TST to be high for
// DEGLITCH_LEN consecutive cycles before a key attempt may begin.
module tst_mode_dec
   import tst_mode_pkg::*;
#(
   parameter int                KEY_W    = KEY_W_DEF,
   parameter logic [KEY_W-1:0]  KEY_SCAN = KEY_SCAN_DEF,
   parameter logic [KEY_W-1:0]  KEY_IDDQ = KEY_IDDQ_DEF,
   parameter int                TMO_W    = TMO_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tst,
   input  logic       i_sck,
   input  logic       i_sda,
   output logic       o_scan_mode,
   output logic       o_iddq_mode,
   output logic       o_test_any,
   output logic       o_key_err,
   output logic [4:0] o_bitcnt
);

   localparam logic [4:0]       BIT_LAST = 5'(KEY_W - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

   logic             tst_s;
   logic             tst_rise;
   logic             sck_s;
   logic             sck_rise;
   logic             sda_s;
   logic             sda_rise;
   logic             unused_rise;

   state_t           state;
   logic [KEY_W-1:0] shreg;
   logic [TMO_W-1:0] tmo;

`ifdef TST_DEGLITCH_EN
   logic [2:0]       deg_cnt;
`endif

   tst_sync_edge u_sync_tst (
      .clk  (clk),
      .rst  (rst),
      .pad  (i_tst),
      .sync (tst_s),
      .rise (tst_rise)
   );

   tst_sync_edge u_sync_sck (
      .clk  (clk),
      .rst  (rst),
      .pad  (i_sck),
      .sync (sck_s),
      .rise (sck_rise)
   );

   tst_sync_edge u_sync_sda (
      .clk  (clk),
      .rst  (rst),
      .pad  (i_sda),
      .sync (sda_s),
      .rise (sda_rise)
   );

   // Only the strobe edge matters; tst and sda are used as levels.
   assign unused_rise = tst_rise | sda_rise | sck_s;

   assign o_test_any = o_scan_mode | o_iddq_mode;

   // Key-entry FSM with registered mode/error outputs and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         tmo         <= '0;
         o_bitcnt    <= '0;
         o_scan_mode <= 1'b0;
         o_iddq_mode <= 1'b0;
         o_key_err   <= 1'b0;
`ifdef TST_DEGLITCH_EN
         deg_cnt     <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               shreg       <= '0;
               tmo         <= '0;
               o_bitcnt    <= '0;
               o_scan_mode <= 1'b0;
               o_iddq_mode <= 1'b0;
               o_key_err   <= 1'b0;
`ifdef TST_DEGLITCH_EN
               if (!tst_s) begin
                  deg_cnt <= '0;
               end else if (deg_cnt == 3'(DEGLITCH_LEN - 1)) begin
                  deg_cnt <= '0;
                  state   <= ST_SHIFT;
               end else begin
                  deg_cnt <= deg_cnt + 3'd1;
               end
`else
               if (tst_s) begin
                  state <= ST_SHIFT;
               end
`endif
            end

            ST_SHIFT: begin
               if (!tst_s) begin
                  state    <= ST_IDLE;
                  shreg    <= '0;
                  tmo      <= '0;
                  o_bitcnt <= '0;
               end else if (sck_rise) begin
                  shreg    <= {shreg[KEY_W-2:0], sda_s};
                  o_bitcnt <= o_bitcnt + 5'd1;
                  tmo      <= '0;
                  if (o_bitcnt == BIT_LAST) begin
                     state <= ST_CHECK;
                  end
               end else if (o_bitcnt != 5'd0) begin
                  if (tmo == TMO_MAX) begin
                     shreg    <= '0;
                     tmo      <= '0;
                     o_bitcnt <= '0;
                  end else begin
                     tmo <= tmo + 1'b1;
                  end
               end
            end

            ST_CHECK: begin
               if (shreg == KEY_SCAN) begin
                  o_scan_mode <= 1'b1;
                  state       <= ST_SCAN;
               end else if (shreg == KEY_IDDQ) begin
                  o_iddq_mode <= 1'b1;
                  state       <= ST_IDDQ;
               end else begin
                  o_key_err <= 1'b1;
                  state     <= ST_LOCK;
               end
            end

            ST_SCAN, ST_IDDQ, ST_LOCK: begin
               if (!tst_s) begin
                  state       <= ST_IDLE;
                  shreg       <= '0;
                  tmo         <= '0;
                  o_bitcnt    <= '0;
                  o_scan_mode <= 1'b0;
                  o_iddq_mode <= 1'b0;
                  o_key_err   <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tst_mode_dec.sv
// Directed self-checking bench for tst_mode_dec: key entry, wrong-key lockout,
// inter-bit timeout, async reset and (when built with it) TST deglitching.
module tb_tst_mode_dec;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_tst;
   logic       i_sck;
   logic       i_sda;
   logic       o_scan_mode;
   logic       o_iddq_mode;
   logic       o_test_any;
   logic       o_key_err;
   logic [4:0] o_bitcnt;

   int passed = 0;
   int total  = 0;

   tst_mode_dec dut (
      .clk         (clk),
      .rst         (rst),
      .i_tst       (i_tst),
      .i_sck       (i_sck),
      .i_sda       (i_sda),
      .o_scan_mode (o_scan_mode),
      .o_iddq_mode (o_iddq_mode),
      .o_test_any  (o_test_any),
      .o_key_err   (o_key_err),
      .o_bitcnt    (o_bitcnt)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   // Advance n rising edges and settle 2 ns past the edge for drive/sample.
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_output(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // One key bit: data set up, strobe high for 10 clk, 20 clk per bit.
   task automatic apply_stimulus(input logic b);
      i_sda = b;
      wait_clk(5);
      i_sck = 1'b1;
      wait_clk(10);
      i_sck = 1'b0;
      wait_clk(5);
   endtask

   // Send the top nbits of key, MSB first.
   task automatic send_key(input logic [15:0] key, input int nbits);
      for (int i = 15; i >= 16 - nbits; i--) apply_stimulus(key[i]);
   endtask

   task automatic check_idle(input string tag);
      check_output({tag, "_scan"}, 16'(o_scan_mode), 16'h0);
      check_output({tag, "_iddq"}, 16'(o_iddq_mode), 16'h0);
      check_output({tag, "_any"},  16'(o_test_any),  16'h0);
      check_output({tag, "_err"},  16'(o_key_err),   16'h0);
      check_output({tag, "_cnt"},  16'(o_bitcnt),    16'h0);
   endtask

   initial begin
      logic [15:0] key;

      // Reset state
      rst   = 1'b1;
      i_tst = 1'b0;
      i_sck = 1'b0;
      i_sda = 1'b0;
      wait_clk(3);
      check_idle("reset");
      rst = 1'b0;
      wait_clk(2);

`ifdef TST_DEGLITCH_EN
      // Short TST pulse, then a strobe arriving before 8 stable cycles.
      $display("[TB] deglitch: short TST pulse");
      i_tst = 1'b1;
      wait_clk(5);
      i_tst = 1'b0;
      wait_clk(1);
      i_tst = 1'b1;
      apply_stimulus(1'b1);
      check_output("dg_nocapture", 16'(o_bitcnt), 16'd0);
      send_key(16'hA5C3, 16);
      check_output("dg_scan", 16'(o_scan_mode), 16'h1);
      i_tst = 1'b0;
      wait_clk(5);
      check_idle("dg_exit");
`endif

      // Scan key with exact grant latency on the final bit
      $display("[TB] scan key");
      key   = 16'hA5C3;
      i_tst = 1'b1;
      wait_clk(12);
      send_key(key, 15);
      check_output("scan_cnt15", 16'(o_bitcnt), 16'd15);
      i_sda = key[0];
      wait_clk(5);
      i_sck = 1'b1;
      wait_clk(3);
      check_output("scan_cnt16", 16'(o_bitcnt), 16'd16);
      check_output("scan_early", 16'(o_scan_mode), 16'h0);
      wait_clk(1);
      check_output("scan_grant", 16'(o_scan_mode), 16'h1);
      check_output("scan_iddq0", 16'(o_iddq_mode), 16'h0);
      check_output("scan_any",   16'(o_test_any),  16'h1);
      i_sck = 1'b0;
      wait_clk(5);
      apply_stimulus(1'b0);
      check_output("scan_frozen", 16'(o_bitcnt), 16'd16);
      i_tst = 1'b0;
      wait_clk(5);
      check_idle("scan_exit");

      // IDDQ key and exit timing after TST falls
      $display("[TB] iddq key");
      i_tst = 1'b1;
      wait_clk(12);
      send_key(16'h5A3C, 16);
      check_output("iddq_grant", 16'(o_iddq_mode), 16'h1);
      check_output("iddq_any",   16'(o_test_any),  16'h1);
      check_output("iddq_scan0", 16'(o_scan_mode), 16'h0);
      i_tst = 1'b0;
      wait_clk(2);
      check_output("iddq_hold2", 16'(o_iddq_mode), 16'h1);
      wait_clk(1);
      check_idle("iddq_exit");

      // Wrong key locks out until TST falls
      $display("[TB] wrong key");
      i_tst = 1'b1;
      wait_clk(12);
      send_key(16'hFFFF, 16);
      check_output("bad_err",  16'(o_key_err),   16'h1);
      check_output("bad_scan", 16'(o_scan_mode), 16'h0);
      check_output("bad_iddq", 16'(o_iddq_mode), 16'h0);
      send_key(16'hA5C3, 16);
      check_output("lock_err",  16'(o_key_err),   16'h1);
      check_output("lock_scan", 16'(o_scan_mode), 16'h0);
      check_output("lock_cnt",  16'(o_bitcnt),    16'd16);
      i_tst = 1'b0;
      wait_clk(5);
      check_idle("lock_exit");
      i_tst = 1'b1;
      wait_clk(12);
      send_key(16'hA5C3, 16);
      check_output("retry_scan", 16'(o_scan_mode), 16'h1);
      check_output("retry_err",  16'(o_key_err),   16'h0);
      i_tst = 1'b0;
      wait_clk(5);

      // Inter-bit timeout discards a partial key
      $display("[TB] timeout");
      i_tst = 1'b1;
      wait_clk(12);
      send_key(16'hA5C3, 7);
      check_output("tmo_cnt7", 16'(o_bitcnt), 16'd7);
      wait_clk(3000);
      check_output("tmo_before", 16'(o_bitcnt), 16'd7);
      wait_clk(1200);
      check_output("tmo_cleared", 16'(o_bitcnt), 16'd0);
      send_key(16'hA5C3, 16);
      check_output("tmo_scan", 16'(o_scan_mode), 16'h1);
      check_output("tmo_err",  16'(o_key_err),   16'h0);

      // Asynchronous reset while scan mode is held
      $display("[TB] async reset");
      rst = 1'b1;
      #1;
      check_output("arst_scan", 16'(o_scan_mode), 16'h0);
      check_output("arst_any",  16'(o_test_any),  16'h0);
      check_output("arst_cnt",  16'(o_bitcnt),    16'd0);
      wait_clk(1);
      rst = 1'b0;
      wait_clk(1);
      check_output("arst_idle_cnt",  16'(o_bitcnt),    16'd0);
      check_output("arst_idle_scan", 16'(o_scan_mode), 16'h0);
      wait_clk(12);
      send_key(16'hA5C3, 16);
      check_output("arst_regrant", 16'(o_scan_mode), 16'h1);
      i_tst = 1'b0;
      wait_clk(5);
      check_idle("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tst_mode_dec.md
Name: tst_mode_dec

Overview:
- On-chip end of the tester interface: decodes the test-mode entry sequence the ATE applies on the TST, SCL and SDA pads before scan or IDDQ patterns.
- Grants scan_mode or iddq_mode to the chiptop test muxing.
- Sits in the always-on digital domain, fed directly by the pad input buffers.
- Holds the granted mode until TST is released.

Parameters:
- KEY_W, 16, serial key length in bits.
- KEY_SCAN, 16'hA5C3, key granting scan mode.
- KEY_IDDQ, 16'h5A3C, key granting IDDQ mode.
- TMO_W, 12, width of the inter-bit timeout counter; timeout = 2^TMO_W-1 clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- i_tst  input  1  TST pad; asynchronous to clk
- i_sck  input  1  SCL pad used as key strobe; asynchronous
- i_sda  input  1  SDA pad used as key data; asynchronous
- o_scan_mode  output  1  scan mode granted
- o_iddq_mode  output  1  IDDQ mode granted
- o_test_any  output  1  OR of the two mode outputs
- o_key_err  output  1  wrong key received; sticky until TST falls
- o_bitcnt  output  5  bits captured in the current key attempt

Behaviour:
- Reset: all outputs 0; FSM in IDLE; sync flops, shift register and counters cleared.
- Synchronizers: i_tst, i_sck and i_sda each pass through 2 flops.
- Strobe: a bit strobe is the rising edge of synced sck, detected against a third flop. On the strobe cycle E, synced sda is shifted in MSB-first and o_bitcnt increments.
- FSM states: IDLE, SHIFT, CHECK, SCAN, IDDQ, LOCK.
- IDLE: tst_s=1 -> SHIFT; bitcnt=0.
- SHIFT:
  - Strobe -> shift one bit.
  - Strobe that captures bit KEY_W -> CHECK next cycle.
  - tst_s=0 -> IDLE.
- CHECK (exactly 1 cycle):
  - shreg==KEY_SCAN -> SCAN.
  - shreg==KEY_IDDQ -> IDDQ.
  - Otherwise -> LOCK.
  - Output registers update at the end of CHECK, so the mode is visible in cycle E+2.
- SCAN / IDDQ: the corresponding output is 1. Strobes are ignored and bitcnt freezes at 16. tst_s=0 -> IDLE with outputs cleared in the same registered update.
- LOCK: o_key_err=1. Strobes are ignored; no retry without a TST falling edge. tst_s=0 -> IDLE, which clears o_key_err.
- Mode outputs: o_scan_mode and o_iddq_mode are mutually exclusive and never both 1.
- Timeout:
  - In SHIFT with 0<bitcnt<KEY_W, the timeout counter increments each cycle without a strobe and is cleared on every strobe.
  - On reaching all-ones, bitcnt and shreg clear and the FSM stays in SHIFT.
  - No timeout while bitcnt=0.
- Simultaneous events: tst_s falling in the same cycle as a strobe -> IDLE wins; the bit is discarded.
- Reset mid-operation: rst asserted while in SCAN or IDDQ clears the mode asynchronously.
- Width: bitcnt saturates at KEY_W; no wrap.

Optional Feature:
- Macro: TST_DEGLITCH_EN.
- Defined:
  - tst_s must be stable high for 8 consecutive clk cycles (3-bit counter) before IDLE->SHIFT.
  - Any low sample restarts the count.
  - Exit on falling tst_s stays immediate.
- Undefined: IDLE->SHIFT on the first tst_s=1 cycle.

Decomposition:
- Package tst_mode_pkg holds:
  - the FSM state enum (3-bit encoding);
  - KEY_W, KEY_SCAN and KEY_IDDQ default constants;
  - the deglitch length constant.
- One sub-module, tst_sync_edge: a 2-flop synchronizer plus rising-edge detect, instantiated three times. The tst and sda instances leave the edge output unused.

Test Plan:
- Key 16'hA5C3 with TST=1, strobes every 20 clk -> o_scan_mode=1 exactly 2 clk after the 16th strobe is detected; o_iddq_mode=0; o_bitcnt=16.
- Key 16'h5A3C -> o_iddq_mode=1, o_test_any=1. Then TST=0 -> all outputs 0 within 3 clk of the pad edge (2 sync + 1).
- Key 16'hFFFF -> o_key_err=1, modes stay 0. Then 16 more strobes carrying A5C3 with TST held high -> still LOCK. Then TST low→high and resend A5C3 -> o_scan_mode=1.
- 7 bits sent, gap of 4096 clk, then 16 bits of A5C3 -> o_bitcnt returns to 0 after the gap; scan granted.
- rst pulse while o_scan_mode=1 -> all outputs 0 immediately (async); IDLE after release even with TST=1 until the next cycle.
- TST_DEGLITCH_EN build:
  - TST high for 5 clk then low, then a key sent -> no bits captured.
  - TST held high ≥8 clk, then A5C3 -> scan granted.
